// File: rtl/mux2_unit.sv
// Two-input selector (O = S ? B : A) with an optional output register.
// REGISTERED=1 gives one cycle of latency; REGISTERED=0 is pure glue logic.
module mux2_unit #(
  parameter int unsigned       WIDTH      = 1,
  parameter bit                REGISTERED = 1'b1,
  parameter logic [WIDTH-1:0]  RESET_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             S,
  input  logic             en,
  output logic [WIDTH-1:0] O,
  output logic             O_valid
);

  // An X on s yields X wherever a and b differ, and the common value where they agree.
  function automatic logic [WIDTH-1:0] select_fn(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic             s);
    return s ? b : a;
  endfunction

  logic [WIDTH-1:0] sel_p0;

  assign sel_p0 = select_fn(A, B, S);

  generate
    if (REGISTERED) begin : g_reg
      logic [WIDTH-1:0] o_p1;
      logic             vld_p1;

      // Stage p0 -> p1: capture selected data; reset discards any pending capture.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          o_p1   <= RESET_VAL;
          vld_p1 <= 1'b0;
        end else if (en) begin
          o_p1   <= sel_p0;
          vld_p1 <= 1'b1;
        end
      end

      assign O       = o_p1;
      assign O_valid = vld_p1;
    end else begin : g_comb
      logic unused_ctrl;

      assign unused_ctrl = &{1'b0, clk, en};
      assign O           = sel_p0;
      assign O_valid     = rst_n;
    end
  endgenerate

endmodule

// File: tb/tb_mux2_unit.sv
// Bench for mux2_unit: four builds share stimulus; a behavioural model tracks
// the last value captured since reset and is compared on every falling edge.
module tb_mux2_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        s = 1'b0;
  logic        a1 = 1'b0, b1 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] a16 = '0, b16 = '0;

  logic        o1, v1, oc, vc, v8, v16;
  logic [7:0]  o8;
  logic [15:0] o16;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  // Model state: value captured at the latest enabled edge since the last reset.
  logic        m1  = 1'b0;
  logic [7:0]  m8  = 8'hA5;
  logic [15:0] m16 = 16'h0000;
  logic        mv  = 1'b0;

  logic [7:0]  tt = 8'b1101_1000;

  always #5 clk = ~clk;

  mux2_unit #(.WIDTH(1), .REGISTERED(1'b1), .RESET_VAL(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .S(s), .en(en), .O(o1), .O_valid(v1));

  mux2_unit #(.WIDTH(8), .REGISTERED(1'b1), .RESET_VAL(8'hA5)) u8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .S(s), .en(en), .O(o8), .O_valid(v8));

  mux2_unit #(.WIDTH(16), .REGISTERED(1'b1), .RESET_VAL(16'h0000)) u16 (
    .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .S(s), .en(en), .O(o16), .O_valid(v16));

  mux2_unit #(.WIDTH(1), .REGISTERED(1'b0), .RESET_VAL(1'b0)) uc (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .S(s), .en(en), .O(oc), .O_valid(vc));

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n === 1'b1 && en === 1'b1) begin
      m1  = s ? b1 : a1;
      m8  = s ? b8 : a8;
      m16 = s ? b16 : a16;
      mv  = 1'b1;
    end
  end

  always @(negedge rst_n) begin
    m1  = 1'b0;
    m8  = 8'hA5;
    m16 = 16'h0000;
    mv  = 1'b0;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("o1",  {15'd0, o1}, {15'd0, m1});
      chk("o8",  {8'd0, o8},  {8'd0, m8});
      chk("o16", o16, m16);
      chk("v1",  {15'd0, v1},  {15'd0, mv});
      chk("v8",  {15'd0, v8},  {15'd0, mv});
      chk("v16", {15'd0, v16}, {15'd0, mv});
      chk("comb_o", {15'd0, oc}, {15'd0, (s ? b1 : a1)});
      chk("comb_v", {15'd0, vc}, {15'd0, rst_n});
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o8_a5", {8'd0, o8}, 16'h00A5);
    chk("rst_v8",    {15'd0, v8}, 16'h0000);
    chk("rst_o1",    {15'd0, o1}, 16'h0000);
    chk("rst_comb_v", {15'd0, vc}, 16'h0000);

    @(negedge clk); #1;
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // Truth table on the 1-bit builds
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      a1 = i[2]; b1 = i[1]; s = i[0];
      #1;
      chk("tt_comb", {15'd0, oc}, {15'd0, tt[i]});
      @(posedge clk); #1;
      chk("tt_reg", {15'd0, o1}, {15'd0, tt[i]});
    end

    // Asynchronous reset between edges; release waits for the next edge
    @(negedge clk); #1;
    a1 = 1'b1; b1 = 1'b1; s = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_o1", {15'd0, o1}, 16'h0001);
    #1 rst_n = 1'b0;
    #1;
    chk("async_o1", {15'd0, o1}, 16'h0000);
    chk("async_v1", {15'd0, v1}, 16'h0000);
    chk("async_o8", {8'd0, o8}, 16'h00A5);
    chk("async_vc", {15'd0, vc}, 16'h0000);
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rel_o1_hold", {15'd0, o1}, 16'h0000);
    chk("rel_v1_hold", {15'd0, v1}, 16'h0000);
    @(posedge clk); #1;
    chk("rel_o1_edge", {15'd0, o1}, 16'h0001);
    chk("rel_v1_edge", {15'd0, v1}, 16'h0001);

    // Hold with en low
    @(negedge clk); #1;
    a8 = 8'h5A; b8 = 8'hC3; s = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    chk("hold_load", {8'd0, o8}, 16'h005A);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      s = 1'b1; en = 1'b0;
      @(posedge clk); #1;
      chk("hold_en0", {8'd0, o8}, 16'h005A);
    end
    @(negedge clk); #1;
    en = 1'b1;
    @(posedge clk); #1;
    chk("hold_resume", {8'd0, o8}, 16'h00C3);

    // Wide select toggling every cycle
    a16 = 16'hFFFF; b16 = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      s = k[0];
      @(posedge clk); #1;
      chk("wide_toggle", o16, (k[0] ? 16'h0000 : 16'hFFFF));
    end

    // Randomized traffic with sporadic mid-cycle resets
    for (int n = 0; n < 400; n++) begin
      @(negedge clk); #1;
      a1    = 1'($urandom);
      b1    = 1'($urandom);
      a8    = 8'($urandom);
      b8    = (n % 7 == 0) ? a8 : 8'($urandom);
      a16   = 16'($urandom);
      b16   = 16'($urandom);
      s     = 1'($urandom);
      en    = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 24) != 0);
    end

    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
